fifo_queue_param: RTL and testbench
===================================

Name: fifo_queue_param

Overview:
Parametrised synchronous single-clock FIFO. It is the next generation of the fixed 16-bit/8-deep queue, generalised in width and depth. New features over that queue:
- registered read with a valid strobe
- fill count
- programmable almost-full and almost-empty flags
- sticky overflow and underflow error flags
- synchronous flush
It sits between producer/consumer datapath blocks as the standard buffering element.

Parameters:
DATA_WIDTH, 16, width of each stored word
DEPTH, 8, number of entries; must be a power of 2 and >= 2 (elaboration error otherwise)
ALMOST_FULL_THRESH, DEPTH-2, Almost_Full asserts when count >= this value (1..DEPTH)
ALMOST_EMPTY_THRESH, 2, Almost_Empty asserts when count <= this value (0..DEPTH-1)

Ports:
Clk_In  in  1  single clock, rising edge
Reset_N_In  in  1  asynchronous, active-low reset
Flush_In  in  1  synchronous flush; empties FIFO
Data_In  in  DATA_WIDTH  write data
Write_Enable_In  in  1  write request
Read_Enable_In  in  1  read request
Data_Out  out  DATA_WIDTH  read data, registered
Data_Valid_Out  out  1  one-cycle strobe: Data_Out updated this cycle
FIFO_Full  out  1  count == DEPTH
FIFO_Empty  out  1  count == 0
Almost_Full  out  1  count >= ALMOST_FULL_THRESH
Almost_Empty  out  1  count <= ALMOST_EMPTY_THRESH
Fill_Count  out  $clog2(DEPTH+1)  number of stored words
Overflow  out  1  sticky: a write was rejected
Underflow  out  1  sticky: a read was rejected

Behaviour:
- One clock (Clk_In), all state on its rising edge. Reset_N_In is asynchronous and active-low. Reset assertion takes effect immediately, independent of the clock.
- Reset state:
  - write and read pointers = 0, count = 0
  - Data_Out = 0, Data_Valid_Out = 0, Overflow = 0, Underflow = 0
  - therefore FIFO_Empty = 1, FIFO_Full = 0, Almost_Empty = 1, Almost_Full = 0
  - memory contents are not reset
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Fill_Count is a separate register, so full and empty are never ambiguous.
- Read accepted = Read_Enable_In && count != 0.
- Write accepted = Write_Enable_In && (count != DEPTH || read accepted in same cycle).
  - When full, simultaneous read+write is allowed: count stays DEPTH and both pointers advance.
  - When empty, simultaneous read+write: the read is rejected (Underflow sets) and the write is accepted (count becomes 1).
- Read latency is 1 cycle. The word at the read pointer is captured into Data_Out at the accepting edge. Data_Valid_Out is high for exactly the following cycle. Otherwise Data_Out holds its last value and Data_Valid_Out = 0.
- Count update per edge: +1 for write only, -1 for read only, unchanged for both or neither.
- Status flags are combinational decodes of the count register, so they reflect post-edge state with no extra lag.
- Rejected write: data dropped, state unchanged, Overflow set. Rejected read: Data_Out holds, no valid strobe, Underflow set. Both flags are sticky until reset or flush.
- Flush_In has priority over read and write in the same cycle:
  - clears pointers, count, Data_Valid_Out, Overflow and Underflow
  - Data_Out holds its value
  - any read/write requested in the flush cycle is ignored and does not set error flags
- Reset mid-operation: everything returns to the reset state at once. The first write after reset release is stored at entry 0.
- Data ordering is strict first-in first-out across pointer wrap-around.

Decomposition:
- Shared package fifo_pkg holds:
  - a function returning the count width, $clog2(DEPTH+1)
  - a localparam check helper for power-of-2 depth
- Sub-module fifo_mem_sync: DEPTH x DATA_WIDTH register array.
  - synchronous write port (we, waddr, wdata)
  - synchronous read port (re, raddr, rdata registered)
  - no reset on the array
- Top level holds pointers, count, flags, error logic and flush.

Test Plan:
All scenarios use DATA_WIDTH=16, DEPTH=8, AF=6, AE=2.
1. Reset release, then read with empty FIFO -> no Data_Valid_Out, Data_Out=0x0000, Underflow=1, FIFO_Empty=1.
2. Write 0x0001..0x0008 on 8 consecutive cycles:
   - Fill_Count goes 1..8
   - Almost_Empty drops after the 3rd write
   - Almost_Full rises after the 6th write
   - FIFO_Full=1 after the 8th write
   - 9th write 0xDEAD -> Overflow=1, count stays 8
3. From full, 8 consecutive reads -> Data_Out = 0x0001..0x0008 each with Data_Valid_Out, one cycle after each read. 0xDEAD never appears. FIFO_Empty=1 at the end.
4. Wrap-around and simultaneous events:
   - fill 5, read 3, write 6 more (pointer wraps), drain -> exact FIFO order preserved
   - when full, simultaneous read+write -> count stays 8, no Overflow
5. When empty, simultaneous read+write of 0x1234 -> Underflow=1, count=1. Next read returns 0x1234.
6. Flush at count=5 together with a write -> count=0, Overflow/Underflow cleared, written word discarded.
   Separately: Reset_N_In pulsed low between clock edges -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO: per-edge operation encoding
// and elaboration-time sizing helpers.
package fifo_pkg;

   // Bit order matches {write accepted, read accepted}.
   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_READ  = 2'b01,
      OP_WRITE = 2'b10,
      OP_BOTH  = 2'b11
   } fifo_op_e;

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem_sync.sv
// DEPTH x DATA_WIDTH storage with a synchronous write port and a registered
// read port; only the read register is reset, the array itself is not.
module fifo_mem_sync
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0]    i_wdata,
   input  logic                     i_re,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0]    o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   // NOTE: the array has no reset so it maps onto plain storage cells; a
   // reset here would force a flop plus clear logic per bit for no benefit.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // NOTE: non-blocking assignment lets a read and a write to the same
   // address on one edge return the old word, which the full-FIFO
   // simultaneous read+write case relies on.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule : fifo_mem_sync

// File: rtl/fifo_queue_param.sv
// Parametrised single-clock FIFO: pointers, fill count, status decodes,
// sticky error flags and synchronous flush around a registered-read memory.
module fifo_queue_param
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH          = 16,
   parameter int DEPTH               = 8,
   parameter int ALMOST_FULL_THRESH  = DEPTH - 2,
   parameter int ALMOST_EMPTY_THRESH = 2
) (
   input  logic                          Clk_In,
   input  logic                          Reset_N_In,
   input  logic                          Flush_In,
   input  logic [DATA_WIDTH-1:0]         Data_In,
   input  logic                          Write_Enable_In,
   input  logic                          Read_Enable_In,
   output logic [DATA_WIDTH-1:0]         Data_Out,
   output logic                          Data_Valid_Out,
   output logic                          FIFO_Full,
   output logic                          FIFO_Empty,
   output logic                          Almost_Full,
   output logic                          Almost_Empty,
   output logic [count_width(DEPTH)-1:0] Fill_Count,
   output logic                          Overflow,
   output logic                          Underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = count_width(DEPTH);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(ALMOST_FULL_THRESH);
   localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(ALMOST_EMPTY_THRESH);

   if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
      $error("fifo_queue_param: DEPTH must be a power of 2 and >= 2");
   end
   if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > DEPTH) begin : g_bad_af
      $error("fifo_queue_param: ALMOST_FULL_THRESH out of range 1..DEPTH");
   end
   if (ALMOST_EMPTY_THRESH < 0 || ALMOST_EMPTY_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("fifo_queue_param: ALMOST_EMPTY_THRESH out of range 0..DEPTH-1");
   end

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_data_valid;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_full;
   logic             w_empty;
   logic             w_rd_acc;
   logic             w_wr_acc;
   logic             w_rd_rej;
   logic             w_wr_rej;
   fifo_op_e         w_op;
   logic [CNT_W-1:0] w_count_next;

   assign w_full  = (r_count == CNT_FULL);
   assign w_empty = (r_count == '0);

   // Flush masks every request, so nothing is accepted or flagged that cycle.
   assign w_rd_acc = Read_Enable_In  && !w_empty && !Flush_In;
   assign w_wr_acc = Write_Enable_In && (!w_full || w_rd_acc) && !Flush_In;
   assign w_rd_rej = Read_Enable_In  && !w_rd_acc && !Flush_In;
   assign w_wr_rej = Write_Enable_In && !w_wr_acc && !Flush_In;

   assign w_op = fifo_op_e'({w_wr_acc, w_rd_acc});

   // NOTE: the default assignment ahead of the case keeps this block
   // purely combinational; a missing path would otherwise infer a latch.
   always_comb begin
      w_count_next = r_count;
      unique case (w_op)
         OP_WRITE: w_count_next = r_count + CNT_W'(1);
         OP_READ:  w_count_next = r_count - CNT_W'(1);
         default:  w_count_next = r_count;
      endcase
   end

   always_ff @(posedge Clk_In or negedge Reset_N_In) begin
      if (!Reset_N_In) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_data_valid <= 1'b0;
         r_overflow   <= 1'b0;
         r_underflow  <= 1'b0;
      end else if (Flush_In) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_data_valid <= 1'b0;
         r_overflow   <= 1'b0;
         r_underflow  <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count      <= w_count_next;
         r_data_valid <= w_rd_acc;
         if (w_wr_rej) begin
            r_overflow <= 1'b1;
         end
         if (w_rd_rej) begin
            r_underflow <= 1'b1;
         end
      end
   end

   // The memory read register doubles as Data_Out, so it holds on flush.
   fifo_mem_sync #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .i_clk   (Clk_In),
      .i_rst_n (Reset_N_In),
      .i_we    (w_wr_acc),
      .i_waddr (r_wr_ptr),
      .i_wdata (Data_In),
      .i_re    (w_rd_acc),
      .i_raddr (r_rd_ptr),
      .o_rdata (Data_Out)
   );

   assign Data_Valid_Out = r_data_valid;
   assign FIFO_Full      = w_full;
   assign FIFO_Empty     = w_empty;
   assign Almost_Full    = (r_count >= CNT_AF);
   assign Almost_Empty   = (r_count <= CNT_AE);
   assign Fill_Count     = r_count;
   assign Overflow       = r_overflow;
   assign Underflow      = r_underflow;

endmodule : fifo_queue_param

// File: tb/tb_fifo_queue_param.sv
// Directed bench for fifo_queue_param (16 x 8, AF=6, AE=2): a vector table
// for fill/drain plus model-checked sequences for wrap, flush and reset.
module tb_fifo_queue_param;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic [15:0] wdata;
   logic        we;
   logic        re;
   logic [15:0] dout;
   logic        dvalid;
   logic        full;
   logic        empty;
   logic        afull;
   logic        aempty;
   logic [3:0]  fill;
   logic        ovf;
   logic        udf;

   int n_checks = 0;
   int n_errors = 0;

   fifo_queue_param #(
      .DATA_WIDTH          (16),
      .DEPTH               (8),
      .ALMOST_FULL_THRESH  (6),
      .ALMOST_EMPTY_THRESH (2)
   ) dut (
      .Clk_In          (clk),
      .Reset_N_In      (rst_n),
      .Flush_In        (flush),
      .Data_In         (wdata),
      .Write_Enable_In (we),
      .Read_Enable_In  (re),
      .Data_Out        (dout),
      .Data_Valid_Out  (dvalid),
      .FIFO_Full       (full),
      .FIFO_Empty      (empty),
      .Almost_Full     (afull),
      .Almost_Empty    (aempty),
      .Fill_Count      (fill),
      .Overflow        (ovf),
      .Underflow       (udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        flush;
      logic        we;
      logic [15:0] wdata;
      logic        re;
      logic [15:0] e_dout;
      logic        e_valid;
      int          e_cnt;
      logic        e_ovf;
      logic        e_udf;
   } vec_t;

   vec_t vecs[$];

   // Reference model used by the hand-written sequences.
   logic [15:0] m_q[$];
   logic [15:0] m_dout;
   logic        m_valid;
   logic        m_ovf;
   logic        m_udf;

   function automatic vec_t mk(logic fl, logic w, logic [15:0] wd, logic r,
                               logic [15:0] ed, logic ev, int ec, logic eo, logic eu);
      vec_t v;
      v.flush = fl; v.we = w; v.wdata = wd; v.re = r;
      v.e_dout = ed; v.e_valid = ev; v.e_cnt = ec; v.e_ovf = eo; v.e_udf = eu;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Status flags are derived from the expected count using AF=6, AE=2.
   task automatic check_outputs(string tag, logic [15:0] e_dout, logic e_valid,
                                int e_cnt, logic e_ovf, logic e_udf);
      check({tag, " Data_Out"},       32'(dout),   32'(e_dout));
      check({tag, " Data_Valid_Out"}, 32'(dvalid), 32'(e_valid));
      check({tag, " Fill_Count"},     32'(fill),   32'(e_cnt));
      check({tag, " FIFO_Full"},      32'(full),   32'(e_cnt == 8));
      check({tag, " FIFO_Empty"},     32'(empty),  32'(e_cnt == 0));
      check({tag, " Almost_Full"},    32'(afull),  32'(e_cnt >= 6));
      check({tag, " Almost_Empty"},   32'(aempty), 32'(e_cnt <= 2));
      check({tag, " Overflow"},       32'(ovf),    32'(e_ovf));
      check({tag, " Underflow"},      32'(udf),    32'(e_udf));
   endtask

   task automatic drive_and_step(logic fl, logic w, logic [15:0] wd, logic r);
      flush = fl;
      we    = w;
      wdata = wd;
      re    = r;
      @(posedge clk);
      #1;
   endtask

   // One clock of stimulus, model update, and comparison against the model.
   task automatic cycle(string tag, logic fl, logic w, logic [15:0] wd, logic r);
      logic rd_ok;
      logic wr_ok;
      if (fl) begin
         m_q.delete();
         m_valid = 1'b0;
         m_ovf   = 1'b0;
         m_udf   = 1'b0;
      end else begin
         rd_ok = r && (m_q.size() != 0);
         wr_ok = w && ((m_q.size() != 8) || rd_ok);
         m_valid = rd_ok;
         if (rd_ok) m_dout = m_q.pop_front();
         if (r && !rd_ok) m_udf = 1'b1;
         if (w && !wr_ok) m_ovf = 1'b1;
         if (wr_ok) m_q.push_back(wd);
      end
      drive_and_step(fl, w, wd, r);
      check_outputs(tag, m_dout, m_valid, m_q.size(), m_ovf, m_udf);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_dout  = 16'h0000;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      we    = 1'b0;
      re    = 1'b0;
      wdata = 16'h0000;

      // Empty read, fill 1..8, rejected 0xDEAD, then drain 8 and idle.
      vecs.push_back(mk(0, 0, 16'h0000, 1, 16'h0000, 0, 0, 0, 1));
      for (int k = 1; k <= 8; k++)
         vecs.push_back(mk(0, 1, 16'(k), 0, 16'h0000, 0, k, 0, 1));
      vecs.push_back(mk(0, 1, 16'hDEAD, 0, 16'h0000, 0, 8, 1, 1));
      for (int j = 1; j <= 8; j++)
         vecs.push_back(mk(0, 0, 16'h0000, 1, 16'(j), 1, 8 - j, 1, 1));
      vecs.push_back(mk(0, 0, 16'h0000, 0, 16'h0008, 0, 0, 1, 1));

      repeat (2) @(posedge clk);
      #1;
      check_outputs("in reset", 16'h0000, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive_and_step(vecs[i].flush, vecs[i].we, vecs[i].wdata, vecs[i].re);
         check_outputs($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_valid,
                       vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_udf);
      end

      // Bring the model in line with the post-table state.
      model_reset();
      m_dout = 16'h0008;
      m_ovf  = 1'b1;
      m_udf  = 1'b1;

      // Wrap-around: fill 5, read 3, write 6 (write pointer wraps), full r+w, drain.
      cycle("flush clr", 1, 0, 16'h0000, 0);
      for (int i = 0; i < 5; i++) cycle($sformatf("wrap wr%0d", i), 0, 1, 16'h0100 + 16'(i), 0);
      for (int i = 0; i < 3; i++) cycle($sformatf("wrap rd%0d", i), 0, 0, 16'h0000, 1);
      for (int i = 0; i < 6; i++) cycle($sformatf("wrap wr2_%0d", i), 0, 1, 16'h0200 + 16'(i), 0);
      cycle("full r+w", 0, 1, 16'h0300, 1);
      for (int i = 0; i < 8; i++) cycle($sformatf("drain%0d", i), 0, 0, 16'h0000, 1);

      // Empty simultaneous read+write: read rejected, write stored.
      cycle("flush2", 1, 0, 16'h0000, 0);
      cycle("empty r+w", 0, 1, 16'h1234, 1);
      cycle("read 1234", 0, 0, 16'h0000, 1);

      // Flush at count 5 alongside a write: word discarded, flags cleared.
      for (int i = 0; i < 5; i++) cycle($sformatf("pre-flush wr%0d", i), 0, 1, 16'h0500 + 16'(i), 0);
      cycle("flush+wr", 1, 1, 16'hBEEF, 1);
      cycle("post-flush wr", 0, 1, 16'h0A0A, 0);
      cycle("post-flush rd", 0, 0, 16'h0000, 1);

      // Asynchronous reset between edges while data is pending.
      for (int i = 0; i < 3; i++) cycle($sformatf("pre-rst wr%0d", i), 0, 1, 16'h0C00 + 16'(i), 0);
      cycle("pre-rst rd", 0, 0, 16'h0000, 1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async reset", m_dout, m_valid, m_q.size(), m_ovf, m_udf);
      @(negedge clk);
      rst_n = 1'b1;
      cycle("post-rst wr", 0, 1, 16'hC0DE, 0);
      cycle("post-rst rd", 0, 0, 16'h0000, 1);
      cycle("post-rst idle", 0, 0, 16'h0000, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_fifo_queue_param
